// File: rtl/byte_fifo.sv
// Byte-wide synchronous queue with show-ahead head data and an occupancy count.
// A push is accepted when the queue is full only if a pop occurs in the same cycle.
module byte_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            wdata,
   input  logic                  push,
   input  logic                  pop,
   output logic [7:0]            rdata,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign level   = count;
   assign rdata   = mem[rptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; contents are only observable once level is non-zero.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Bridges a host byte interface to a UART transmitter/receiver pair through
// one queue per direction, with a three-state drain FSM on the transmit side.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a queued byte and txready; pops head into txdata
// ST_STROBE| txstrobe high for this single cycle, txdata stable
// ST_GUARD | one dead cycle while the transmitter drops txready
module uart_fifo_bridge #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            tx_wdata,
   input  logic                  tx_wen,
   output logic                  tx_full,
   output logic [DEPTH_LOG2:0]   tx_level,
   output logic [7:0]            txdata,
   output logic                  txstrobe,
   input  logic                  txready,
   input  logic [7:0]            rxdata,
   input  logic                  rxstrobe,
   output logic [7:0]            rx_rdata,
   output logic                  rx_valid,
   input  logic                  rx_ren,
   output logic [DEPTH_LOG2:0]   rx_level,
   output logic                  rx_overflow,
   input  logic                  rx_ovf_clr
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STROBE = 2'd1,
      ST_GUARD  = 2'd2
   } tx_state_t;

   tx_state_t  state;
   tx_state_t  state_nxt;
   logic       tx_pop;
   logic       tx_empty;
   logic [7:0] tx_head;
   logic       rx_full;
   logic       rx_empty;
   logic       rx_pop_ok;

   // A write into a full TX queue is dropped even if the drain pops that cycle.
   byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .wdata (tx_wdata),
      .push  (tx_wen & ~tx_full),
      .pop   (tx_pop),
      .rdata (tx_head),
      .full  (tx_full),
      .empty (tx_empty),
      .level (tx_level)
   );

   always_comb begin
      state_nxt = state;
      tx_pop    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!tx_empty && txready) begin
               tx_pop    = 1'b1;
               state_nxt = ST_STROBE;
            end
         end
         ST_STROBE: state_nxt = ST_GUARD;
         ST_GUARD:  state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         txdata <= 8'h00;
      end else begin
         state <= state_nxt;
         if (tx_pop) txdata <= tx_head;
      end
   end

   assign txstrobe = (state == ST_STROBE);

   // The RX queue accepts a push while full when the host pops in the same cycle.
   byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .wdata (rxdata),
      .push  (rxstrobe),
      .pop   (rx_ren),
      .rdata (rx_rdata),
      .full  (rx_full),
      .empty (rx_empty),
      .level (rx_level)
   );

   assign rx_valid  = ~rx_empty;
   assign rx_pop_ok = rx_ren & rx_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_overflow <= 1'b0;
      end else if (rxstrobe && rx_full && !rx_pop_ok) begin
         rx_overflow <= 1'b1;
      end else if (rx_ovf_clr) begin
         rx_overflow <= 1'b0;
      end
   end

endmodule
